// File: rtl/crypto_acc_mmio.sv
// crypto_acc_mmio: memory-mapped front end for a block-cipher core.
// Software loads a key and a data buffer and then sets START. The FSM
// offers the data one block at a time to the core and collects each
// result block into the result buffer.
module crypto_acc_mmio #(
   parameter int                   BUS_WIDTH    = 32,
   parameter logic [BUS_WIDTH-1:0] BASE_ADDRESS = BUS_WIDTH'(32'hF4000000),
   parameter int                   BUF_WORDS    = 16,
   parameter int                   BLOCK_WORDS  = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             read_en_i,
   input  logic                             write_en_i,
   input  logic [BUS_WIDTH-1:0]             addr_i,
   input  logic [BUS_WIDTH-1:0]             data_i,
   output logic [BUS_WIDTH-1:0]             data_o,
   output logic                             irq_o,
   output logic [BLOCK_WORDS*BUS_WIDTH-1:0] core_key_o,
   output logic [BLOCK_WORDS*BUS_WIDTH-1:0] core_blk_o,
   output logic                             core_decrypt_o,
   output logic                             core_valid_o,
   input  logic                             core_ready_i,
   input  logic [BLOCK_WORDS*BUS_WIDTH-1:0] core_res_i,
   input  logic                             core_res_valid_i
);

   localparam int AW = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;
   localparam int KW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

   localparam logic [15:0] L_OFF_CTRL   = 16'h0000;
   localparam logic [15:0] L_OFF_OPTS   = 16'h0004;
   localparam logic [15:0] L_OFF_STATUS = 16'h0008;
   localparam logic [15:0] L_OFF_DLEN   = 16'h0108;
   localparam logic [15:0] L_OFF_RLEN   = 16'h010C;

   localparam logic [BUS_WIDTH-1:0] L_BLOCK = BUS_WIDTH'(BLOCK_WORDS);
   localparam logic [BUS_WIDTH-1:0] L_BUF   = BUS_WIDTH'(BUF_WORDS);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic [1:0]           r_state;
   logic                 r_irq_en;
   logic [BUS_WIDTH-1:0] r_opts;
   logic                 r_done;
   logic                 r_err;
   logic [BUS_WIDTH-1:0] r_data_len;
   logic [BUS_WIDTH-1:0] r_result_len;
   logic [BUS_WIDTH-1:0] r_key    [BLOCK_WORDS];
   logic [BUS_WIDTH-1:0] r_data   [BUF_WORDS];
   logic [BUS_WIDTH-1:0] r_result [BUF_WORDS];
   logic [BUS_WIDTH-1:0] r_data_o;

   logic [BUS_WIDTH-1:0] w_off;
   logic [15:0]          w_off16;
   logic [11:0]          w_idx;
   logic                 w_in_win;
   logic                 w_aligned;
   logic                 w_key_hit;
   logic                 w_data_hit;
   logic                 w_res_hit;
   logic                 w_wr;
   logic                 w_wr_ctrl;
   logic                 w_wr_opts;
   logic                 w_wr_status;
   logic                 w_wr_dlen;
   logic                 w_busy;
   logic                 w_abort;
   logic                 w_start;
   logic                 w_len_bad;
   logic                 w_res_take;
   logic [AW-1:0]        w_base;
   logic [BUS_WIDTH-1:0] w_rd_data;

   // Address decode: window check, register offsets and buffer regions.
   always_comb begin
      w_off      = addr_i - BASE_ADDRESS;
      w_off16    = w_off[15:0];
      w_idx      = w_off16[13:2];
      w_in_win   = (w_off[BUS_WIDTH-1:16] == '0);
      w_aligned  = (w_off16[1:0] == 2'b00);
      w_key_hit  = w_in_win && w_aligned && (w_off16[15:14] == 2'b01) && (w_idx < 12'(BLOCK_WORDS));
      w_data_hit = w_in_win && w_aligned && (w_off16[15:14] == 2'b10) && (w_idx < 12'(BUF_WORDS));
      w_res_hit  = w_in_win && w_aligned && (w_off16[15:14] == 2'b11) && (w_idx < 12'(BUF_WORDS));
   end

   // Write strobes and control-pulse qualification.
   always_comb begin
      w_busy      = (r_state != S_IDLE);
      w_wr        = write_en_i && w_in_win;
      w_wr_ctrl   = w_wr && (w_off16 == L_OFF_CTRL);
      w_wr_opts   = w_wr && (w_off16 == L_OFF_OPTS) && !w_busy;
      w_wr_status = w_wr && (w_off16 == L_OFF_STATUS);
      w_wr_dlen   = w_wr && (w_off16 == L_OFF_DLEN) && !w_busy;
      w_abort     = w_wr_ctrl && data_i[1];
      // ABORT in the same write wins over START.
      w_start     = w_wr_ctrl && data_i[0] && !data_i[1] && !w_busy;
      w_len_bad   = (r_data_len == '0) || (r_data_len > L_BUF) ||
                    ((r_data_len % L_BLOCK) != '0);
      w_res_take  = (r_state == S_WAIT) && core_res_valid_i && !w_abort;
      // RESULT_LEN equals the word index of the block in flight.
      w_base      = r_result_len[AW-1:0];
   end

   // FSM plus control/status registers; FSM events override a same-cycle W1C.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= S_IDLE;
         r_irq_en     <= 1'b0;
         r_opts       <= '0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_data_len   <= '0;
         r_result_len <= '0;
      end else begin
         if (w_wr_ctrl) begin
            r_irq_en <= data_i[2];
         end
         if (w_wr_opts) begin
            r_opts <= data_i;
         end
         if (w_wr_dlen) begin
            r_data_len <= data_i;
         end
         if (w_wr_status) begin
            if (data_i[1]) begin
               r_done <= 1'b0;
            end
            if (data_i[2]) begin
               r_err <= 1'b0;
            end
         end
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  if (w_len_bad) begin
                     r_err <= 1'b1;
                  end else begin
                     r_state      <= S_SEND;
                     r_done       <= 1'b0;
                     r_result_len <= '0;
                  end
               end
            end
            S_SEND: begin
               if (w_abort) begin
                  r_state <= S_IDLE;
               end else if (core_ready_i) begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_abort) begin
                  r_state <= S_IDLE;
               end else if (core_res_valid_i) begin
                  r_result_len <= r_result_len + L_BLOCK;
                  if ((r_result_len + L_BLOCK) < r_data_len) begin
                     r_state <= S_SEND;
                  end else begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Key and data buffers: bus-writable only while idle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < BLOCK_WORDS; i++) begin
            r_key[i] <= '0;
         end
         for (int i = 0; i < BUF_WORDS; i++) begin
            r_data[i] <= '0;
         end
      end else begin
         if (w_wr && w_key_hit && !w_busy) begin
            r_key[w_idx[KW-1:0]] <= data_i;
         end
         if (w_wr && w_data_hit && !w_busy) begin
            r_data[w_idx[AW-1:0]] <= data_i;
         end
      end
   end

   // Result buffer: a whole result block lands in one cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < BUF_WORDS; i++) begin
            r_result[i] <= '0;
         end
      end else begin
         if (w_res_take) begin
            for (int j = 0; j < BLOCK_WORDS; j++) begin
               r_result[w_base + AW'(j)] <= core_res_i[j*BUS_WIDTH +: BUS_WIDTH];
            end
         end
      end
   end

   // Read mux from current (pre-write) register state.
   always_comb begin
      w_rd_data = '0;
      if (w_in_win) begin
         case (w_off16)
            L_OFF_CTRL:   w_rd_data = BUS_WIDTH'({r_irq_en, 2'b00});
            L_OFF_OPTS:   w_rd_data = r_opts;
            L_OFF_STATUS: w_rd_data = BUS_WIDTH'({r_err, r_done, w_busy});
            L_OFF_DLEN:   w_rd_data = r_data_len;
            L_OFF_RLEN:   w_rd_data = r_result_len;
            default: begin
               if (w_key_hit) begin
                  w_rd_data = r_key[w_idx[KW-1:0]];
               end else if (w_data_hit) begin
                  w_rd_data = r_data[w_idx[AW-1:0]];
               end else if (w_res_hit) begin
                  w_rd_data = r_result[w_idx[AW-1:0]];
               end else begin
                  w_rd_data = '0;
               end
            end
         endcase
      end else begin
         w_rd_data = '0;
      end
   end

   // Registered read data; holds while no read is strobed.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_data_o <= '0;
      end else if (read_en_i) begin
         r_data_o <= w_rd_data;
      end
   end

   // Core-facing buses: key and current data block, word 0 in the LSBs.
   always_comb begin
      core_key_o = '0;
      core_blk_o = '0;
      for (int j = 0; j < BLOCK_WORDS; j++) begin
         core_key_o[j*BUS_WIDTH +: BUS_WIDTH] = r_key[j];
         core_blk_o[j*BUS_WIDTH +: BUS_WIDTH] = r_data[w_base + AW'(j)];
      end
   end

   assign data_o         = r_data_o;
   assign irq_o          = r_done & r_irq_en;
   assign core_decrypt_o = r_opts[0];
   assign core_valid_o   = (r_state == S_SEND);

endmodule

// File: doc/crypto_acc_mmio.md
CRYPTO_ACC_MMIO -- requirements
Module: crypto_acc_mmio

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32: bus data and address width.
REQ-002 SHALL have parameter BASE_ADDRESS, default 32'hF4000000: base of the 64 KiB register window.
REQ-003 SHALL have parameter BUF_WORDS, default 16: depth in words of the data buffer and of the result buffer.
REQ-004 SHALL have parameter BLOCK_WORDS, default 4: words per cipher block; the key buffer also holds BLOCK_WORDS words.
REQ-005 SHALL have one clock; reset is asynchronous and active-high.
REQ-006 clk_i  in  1  clock; all logic on the rising edge.
REQ-007 rst_i  in  1  asynchronous active-high reset.
REQ-008 read_en_i  in  1  bus read strobe.
REQ-009 write_en_i  in  1  bus write strobe.
REQ-010 addr_i  in  BUS_WIDTH  byte address.
REQ-011 data_i  in  BUS_WIDTH  write data.
REQ-012 data_o  out  BUS_WIDTH  registered read data.
REQ-013 irq_o  out  1  completion interrupt, level.
REQ-014 core_key_o  out  BLOCK_WORDS*BUS_WIDTH  key; word 0 is in the LSBs.
REQ-015 core_blk_o  out  BLOCK_WORDS*BUS_WIDTH  input block; word 0 is in the LSBs.
REQ-016 core_decrypt_o  out  1  OPTS bit0.
REQ-017 core_valid_o  out  1  block offer to the core.
REQ-018 core_ready_i  in  1  core accepts the offered block.
REQ-019 core_res_i  in  BLOCK_WORDS*BUS_WIDTH  result block.
REQ-020 core_res_valid_i  in  1  result strobe, one cycle.

Function
REQ-021 Decode: off = addr_i - BASE_ADDRESS. Access is in-window iff off < 32'h10000.
REQ-022 Offsets SHALL be: CTRL 0x000 RW; OPTS 0x004 RW; STATUS 0x008 R/W1C; DATA_LEN 0x108 RW (words); RESULT_LEN 0x10C R; KEY buffer 0x4000+4i; DATA buffer 0x8000+4i; RESULT buffer 0xC000+4i (R).
REQ-023 CTRL bit0 START is write-1 pulse and reads 0. CTRL bit1 ABORT is write-1 pulse and reads 0. CTRL bit2 IRQ_EN is stored.
REQ-024 STATUS bits SHALL be bit0 BUSY, bit1 DONE, bit2 ERR. Writing 1 to DONE or ERR clears that bit; BUSY is read-only.
REQ-025 Read data SHALL appear on data_o one cycle after read_en_i.
- Reads of unmapped, out-of-window, or out-of-range buffer index (i>=KEY/BUF size) return 0.
- data_o holds its value when read_en_i is low.
REQ-026 Writes to unmapped, out-of-window, read-only, or out-of-range locations SHALL have no effect.
REQ-027 Simultaneous read and write to the same location SHALL return the pre-write value.
REQ-028 While BUSY, writes to KEY, DATA, OPTS and DATA_LEN SHALL be ignored. CTRL ABORT and IRQ_EN remain writable.
REQ-029 FSM states SHALL be IDLE, SEND, WAIT.
REQ-030 IDLE + START check:
- If DATA_LEN==0, DATA_LEN>BUF_WORDS, or DATA_LEN%BLOCK_WORDS!=0: set ERR, stay IDLE.
- Otherwise: set BUSY, clear DONE, blk=0, RESULT_LEN=0, go to SEND.
REQ-031 SEND SHALL drive core_valid_o=1 with core_blk_o = DATA[blk*BLOCK_WORDS +: BLOCK_WORDS]. core_blk_o is stable until core_valid_o&&core_ready_i, then the FSM goes to WAIT.
REQ-032 WAIT SHALL drive core_valid_o=0. On core_res_valid_i:
- Write all BLOCK_WORDS result words to RESULT[blk*BLOCK_WORDS ..] in one cycle.
- RESULT_LEN += BLOCK_WORDS; blk++.
- Go to SEND if blk*BLOCK_WORDS < DATA_LEN; else go to IDLE, clear BUSY, set DONE.
REQ-033 core_res_valid_i outside WAIT SHALL be ignored.
REQ-034 START while BUSY SHALL be ignored.
REQ-035 ABORT SHALL:
- Force IDLE and clear BUSY next cycle.
- Leave DONE unset and ERR unchanged.
- Keep RESULT_LEN and results of completed blocks.
- Take priority over a same-cycle core_res_valid_i, whose result is discarded.
REQ-036 irq_o SHALL equal DONE & IRQ_EN, combinationally from registers.
REQ-037 core_key_o SHALL continuously reflect the KEY buffer. core_decrypt_o SHALL continuously reflect OPTS bit0.

Reset
REQ-038 On rst_i=1, immediately and asynchronously:
- FSM to IDLE; all registers and buffers to 0.
- data_o=0, irq_o=0, core_valid_o=0.
REQ-039 Reset mid-operation SHALL abandon the operation with no DONE and no further core handshake.

Verification
REQ-040 Write KEY[0..3], DATA[0..7], DATA_LEN=8, CTRL=0x5. Core returns data XOR key with 2-cycle ready and 3-cycle result delay. Required:
- Two handshakes.
- RESULT[0..7] correct, RESULT_LEN=8.
- STATUS=0x2, irq_o=1.
- STATUS write 0x2 then clears irq_o.
REQ-041 DATA_LEN=6 then START -> STATUS=0x4, no core_valid_o; DATA_LEN=0 and DATA_LEN=20 behave the same.
REQ-042 DATA_LEN=16, ABORT after the second result. Required:
- BUSY=0, DONE=0, RESULT_LEN=8.
- A core_res_valid_i pulse after the abort is ignored.
REQ-043 Read 0xF4000100, read 0xF5000008, read KEY index 4 -> each returns 0; write DATA during BUSY -> DATA read back unchanged.
REQ-044 Assert rst_i asynchronously while in WAIT -> outputs and STATUS are 0 before the next clock edge, and core_valid_o stays 0 afterwards.
